config_chain: RTL and testbench
===============================

CONFIG_CHAIN -- requirements
Module: config_chain

Interface
REQ-001 SHALL have parameter SIZE, default 1000: number of configuration bits held.
REQ-002 SHALL have parameter WIDTH, default 1: number of bits shifted per clock (lane count). SIZE SHALL be a multiple of WIDTH, with SIZE >= 2*WIDTH.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port prog_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port prog_en, input, 1 bit: shift enable; high marks a programming session.
REQ-006 SHALL have port prog_in, input, WIDTH bits: serial data word in.
REQ-007 SHALL have port readback, input, 1 bit: session mode; 1 selects recirculating readback.
REQ-008 SHALL have port prog_out, output, WIDTH bits: chain output to the next block, equal to prog_control[SIZE-1 -: WIDTH].
REQ-009 SHALL have port control, output, SIZE bits: committed configuration to fabric.
REQ-010 SHALL have port commit_done, output, 1 bit: one-cycle pulse after a successful commit.
REQ-011 SHALL have port cfg_err, output, 1 bit: sticky word-count error flag.

Function
REQ-012 The shift register prog_control[SIZE-1:0] SHALL update in every cycle with prog_en=1: {prog_control[SIZE-WIDTH-1:0], d}, where d=prog_in for a load session and d=prog_out for a readback session.
REQ-013 The FSM SHALL have two states: IDLE and SHIFT. IDLE with prog_en=1 SHALL go to SHIFT. SHIFT with prog_en=1 SHALL stay in SHIFT. SHIFT with prog_en=0 SHALL evaluate the session and go to IDLE.
REQ-014 The mode SHALL be latched from readback in the IDLE->SHIFT cycle and held for the whole session; changes of readback mid-session SHALL be ignored.
REQ-015 The word counter SHALL clear in IDLE, increment on each prog_en=1 cycle, and saturate at SIZE/WIDTH+1. Its width SHALL be clog2(SIZE/WIDTH+2).
REQ-016 End-of-load evaluation with count == SIZE/WIDTH: control SHALL be loaded from prog_control on that edge, and commit_done SHALL be 1 for exactly the following cycle.
REQ-017 End-of-load evaluation with count != SIZE/WIDTH (under-run or over-run): control SHALL be unchanged, cfg_err SHALL be set, and commit_done SHALL stay 0.
REQ-018 A readback session SHALL never commit and never set cfg_err. After exactly SIZE/WIDTH cycles, prog_control SHALL equal its pre-session value.
REQ-019 cfg_err SHALL clear on the IDLE->SHIFT transition of the next session, and otherwise hold.
REQ-020 A one-cycle prog_en pulse SHALL be a valid session of count 1.
REQ-021 prog_en low for one cycle between sessions SHALL suffice: the evaluation cycle is IDLE-bound, and a new session may start in the next cycle.
REQ-022 control SHALL never change except per REQ-016 or reset. It SHALL have no glitch or partial update during shifting.

Reset
REQ-023 While prog_rst=1, on each edge: prog_control=0, control=0, state=IDLE, count=0, commit_done=0, cfg_err=0. Reset SHALL take priority over prog_en.
REQ-024 Reset asserted mid-session SHALL abort the session with no commit. A session SHALL restart only after prog_rst=0 and prog_en is seen high from IDLE.

Structure
REQ-025 Package cfg_pkg SHALL hold the FSM state encoding (IDLE=0, SHIFT=1) and a clog2 constant function. No other shared typedefs are needed.
REQ-026 The saturating word counter SHALL be a sub-module cfg_word_counter (params MAX; ports clear, inc, count). Everything else SHALL be flat in config_chain.
REQ-027 Chaining SHALL be by direct prog_out->prog_in connection with a shared prog_clk/prog_en/prog_rst. Equal WIDTH across the chain is required.

Verification (SIZE=16, WIDTH=4)
REQ-028 Reset: assert prog_rst 2 cycles -> control=0x0000, prog_out=0x0, commit_done=0, cfg_err=0.
REQ-029 Load: prog_en=1 for 4 cycles with prog_in 0x1,0x2,0x3,0x4, then prog_en=0 -> control=0x1234 on the evaluation edge, commit_done high exactly 1 cycle, prog_out=0x1.
REQ-030 Under-run: 3 words 0xA,0xB,0xC then prog_en=0 -> cfg_err=1, control stays 0x1234, no commit_done. Next session start -> cfg_err=0.
REQ-031 Over-run: 5 words -> cfg_err=1, control unchanged. A 20-word session -> counter saturated at 5, same result.
REQ-032 Readback: with prog_control=0x1234, readback=1, prog_en high 4 cycles -> prog_out sequence 0x1,0x2,0x3,0x4, final prog_control=0x1234, no commit_done, cfg_err=0. Toggling readback mid-session changes nothing.
REQ-033 Reset mid-load: after 2 words, prog_rst=1 for 1 cycle with prog_en still high -> all state zero, no commit_done. After release, a 4-word session commits normally.

Source files
------------

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared state encoding and constant helpers for the config chain
package cfg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cfg_word_counter.sv
// rtl/cfg_word_counter.sv - saturating session word counter
module cfg_word_counter
  import cfg_pkg::*;
#(
  parameter int MAX = 5,
  localparam int W = clog2(MAX + 1)
) (
  input  logic         prog_clk,
  input  logic         prog_rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clearing and counting in the same cycle yields 1, so the first word of a session is counted.
  logic [W-1:0] base;
  assign base = clear ? '0 : count;

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      count <= '0;
    end else if (inc && base != W'(MAX)) begin
      count <= base + W'(1);
    end else begin
      count <= base;
    end
  end

endmodule

// File: rtl/config_chain.sv
// rtl/config_chain.sv - shift-loaded configuration chain with counted commit and readback
module config_chain
  import cfg_pkg::*;
#(
  parameter int SIZE  = 1000,
  parameter int WIDTH = 1
) (
  input  logic             prog_clk,
  input  logic             prog_rst,
  input  logic             prog_en,
  input  logic [WIDTH-1:0] prog_in,
  input  logic             readback,
  output logic [WIDTH-1:0] prog_out,
  output logic [SIZE-1:0]  control,
  output logic             commit_done,
  output logic             cfg_err
);

  localparam int WORDS = SIZE / WIDTH;
  localparam int CW    = clog2(WORDS + 2);

  state_t            state_q, state_d;
  logic              mode_q;
  logic [SIZE-1:0]   prog_control;
  logic [CW-1:0]     count;
  logic              rb_mode;
  logic [WIDTH-1:0]  d;
  logic              session_end;
  logic              load_ok;
  logic              load_bad;

  assign prog_out = prog_control[SIZE-1 -: WIDTH];

  // The first shift of a session already obeys the incoming mode, before it is latched.
  assign rb_mode     = (state_q == IDLE) ? readback : mode_q;
  assign d           = rb_mode ? prog_out : prog_in;
  assign session_end = (state_q == SHIFT) && !prog_en;
  assign load_ok     = session_end && !mode_q && (count == CW'(WORDS));
  assign load_bad    = session_end && !mode_q && (count != CW'(WORDS));

  cfg_word_counter #(
    .MAX (WORDS + 1)
  ) u_counter (
    .prog_clk (prog_clk),
    .prog_rst (prog_rst),
    .clear    (state_q == IDLE),
    .inc      (prog_en),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (prog_en) state_d = SHIFT;
      SHIFT:   if (!prog_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      prog_control <= '0;
      control      <= '0;
      commit_done  <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      commit_done <= load_ok;
      if (prog_en) begin
        prog_control <= {prog_control[SIZE-WIDTH-1:0], d};
      end
      if (state_q == IDLE && prog_en) begin
        mode_q  <= readback;
        cfg_err <= 1'b0;
      end
      if (load_ok) begin
        control <= prog_control;
      end
      if (load_bad) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_chain.sv
// tb/tb_config_chain.sv - directed vector table plus randomized session checks for config_chain
module tb_config_chain;

  localparam int SIZE  = 16;
  localparam int WIDTH = 4;
  localparam int WORDS = SIZE / WIDTH;

  logic             prog_clk = 1'b0;
  logic             prog_rst;
  logic             prog_en;
  logic [WIDTH-1:0] prog_in;
  logic             readback;
  logic [WIDTH-1:0] prog_out;
  logic [SIZE-1:0]  control;
  logic             commit_done;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 prog_clk = ~prog_clk;

  config_chain #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) dut (
    .prog_clk    (prog_clk),
    .prog_rst    (prog_rst),
    .prog_en     (prog_en),
    .prog_in     (prog_in),
    .readback    (readback),
    .prog_out    (prog_out),
    .control     (control),
    .commit_done (commit_done),
    .cfg_err     (cfg_err)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        rb;
    logic [3:0]  din;
    logic [15:0] ctrl;
    logic [3:0]  dout;
    logic        cd;
    logic        err;
  } vec_t;

  vec_t vt[$];

  // Reference model: the chain is a queue of words, oldest at the front (next out).
  logic [3:0]  mq[$];
  logic [3:0]  sess_words[$];
  bit          m_active;
  bit          m_mode;
  bit          m_err;
  bit          m_commit;
  logic [15:0] m_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic rb, input logic [3:0] din,
                     input logic [15:0] ctrl, input logic [3:0] dout, input logic cd, input logic err);
    vec_t v;
    v.rst = rst; v.en = en; v.rb = rb; v.din = din;
    v.ctrl = ctrl; v.dout = dout; v.cd = cd; v.err = err;
    vt.push_back(v);
  endtask

  task automatic drive_edge(input logic rst, input logic en, input logic rb, input logic [3:0] din);
    prog_rst = rst;
    prog_en  = en;
    readback = rb;
    prog_in  = din;
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [15:0] model_pc();
    return {mq[0], mq[1], mq[2], mq[3]};
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < WORDS; i++) mq.push_back(4'h0);
    sess_words.delete();
    m_active = 0; m_mode = 0; m_err = 0; m_commit = 0; m_ctrl = '0;
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic rb, input logic [3:0] din);
    logic [3:0] w;
    if (rst) begin
      model_reset();
      return;
    end
    m_commit = 0;
    if (en) begin
      if (!m_active) begin
        m_active = 1;
        m_mode   = rb;
        m_err    = 0;
        sess_words.delete();
      end
      w = m_mode ? mq[0] : din;
      sess_words.push_back(w);
      void'(mq.pop_front());
      mq.push_back(w);
    end else if (m_active) begin
      m_active = 0;
      if (!m_mode) begin
        if (sess_words.size() == WORDS) begin
          m_ctrl   = model_pc();
          m_commit = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic rstep(input logic rst, input logic en, input logic rb, input logic [3:0] din);
    drive_edge(rst, en, rb, din);
    model_edge(rst, en, rb, din);
    check("rand_control", control, m_ctrl);
    check("rand_prog_out", prog_out, mq[0]);
    check("rand_commit_done", commit_done, m_commit);
    check("rand_cfg_err", cfg_err, m_err);
  endtask

  initial begin
    int len;
    bit rb0;

    // rst en rb din | control prog_out commit err
    add(1,0,0,4'h0, 16'h0000,4'h0,0,0);
    add(1,0,0,4'h0, 16'h0000,4'h0,0,0);
    add(0,1,0,4'h1, 16'h0000,4'h0,0,0);
    add(0,1,0,4'h2, 16'h0000,4'h0,0,0);
    add(0,1,0,4'h3, 16'h0000,4'h0,0,0);
    add(0,1,0,4'h4, 16'h0000,4'h1,0,0);
    add(0,0,0,4'h0, 16'h1234,4'h1,1,0);
    add(0,0,0,4'h0, 16'h1234,4'h1,0,0);
    add(0,1,0,4'hA, 16'h1234,4'h2,0,0);
    add(0,1,0,4'hB, 16'h1234,4'h3,0,0);
    add(0,1,0,4'hC, 16'h1234,4'h4,0,0);
    add(0,0,0,4'h0, 16'h1234,4'h4,0,1);
    add(0,1,0,4'h1, 16'h1234,4'hA,0,0);
    add(0,1,0,4'h2, 16'h1234,4'hB,0,0);
    add(0,1,0,4'h3, 16'h1234,4'hC,0,0);
    add(0,1,0,4'h4, 16'h1234,4'h1,0,0);
    add(0,0,0,4'h0, 16'h1234,4'h1,1,0);
    add(0,1,0,4'h5, 16'h1234,4'h2,0,0);
    add(0,1,0,4'h6, 16'h1234,4'h3,0,0);
    add(0,1,0,4'h7, 16'h1234,4'h4,0,0);
    add(0,1,0,4'h8, 16'h1234,4'h5,0,0);
    add(0,1,0,4'h9, 16'h1234,4'h6,0,0);
    add(0,0,0,4'h0, 16'h1234,4'h6,0,1);
    add(0,1,0,4'h1, 16'h1234,4'h7,0,0);
    add(0,1,0,4'h2, 16'h1234,4'h8,0,0);
    add(0,1,0,4'h3, 16'h1234,4'h9,0,0);
    add(0,1,0,4'h4, 16'h1234,4'h1,0,0);
    add(0,0,0,4'h0, 16'h1234,4'h1,1,0);
    add(0,1,1,4'hF, 16'h1234,4'h2,0,0);
    add(0,1,0,4'hF, 16'h1234,4'h3,0,0);
    add(0,1,1,4'hF, 16'h1234,4'h4,0,0);
    add(0,1,0,4'hF, 16'h1234,4'h1,0,0);
    add(0,0,0,4'h0, 16'h1234,4'h1,0,0);
    add(0,1,0,4'h5, 16'h1234,4'h2,0,0);
    add(0,1,0,4'h6, 16'h1234,4'h3,0,0);
    add(1,1,0,4'h7, 16'h0000,4'h0,0,0);
    add(0,1,0,4'hA, 16'h0000,4'h0,0,0);
    add(0,1,0,4'hB, 16'h0000,4'h0,0,0);
    add(0,1,0,4'hC, 16'h0000,4'h0,0,0);
    add(0,1,0,4'hD, 16'h0000,4'hA,0,0);
    add(0,0,0,4'h0, 16'hABCD,4'hA,1,0);
    add(0,0,0,4'h0, 16'hABCD,4'hA,0,0);
    add(0,1,0,4'hE, 16'hABCD,4'hB,0,0);
    add(0,0,0,4'h0, 16'hABCD,4'hB,0,1);

    foreach (vt[i]) begin
      drive_edge(vt[i].rst, vt[i].en, vt[i].rb, vt[i].din);
      check($sformatf("vec%0d_control", i), control, vt[i].ctrl);
      check($sformatf("vec%0d_prog_out", i), prog_out, vt[i].dout);
      check($sformatf("vec%0d_commit_done", i), commit_done, vt[i].cd);
      check($sformatf("vec%0d_cfg_err", i), cfg_err, vt[i].err);
    end

    // Long over-run: counter must saturate and the session must fail cleanly.
    model_reset();
    rstep(1, 0, 0, 4'h0);
    for (int i = 0; i < WORDS; i++) rstep(0, 1, 0, 4'(i + 3));
    rstep(0, 0, 0, 4'h0);
    for (int i = 0; i < 20; i++) rstep(0, 1, 0, 4'($urandom_range(0, 15)));
    check("counter_saturated", 32'(dut.u_counter.count), 32'd5);
    rstep(0, 0, 0, 4'h0);
    check("overrun20_err", cfg_err, 1'b1);

    // Random sessions of varied length and mode, with occasional resets.
    for (int s = 0; s < 80; s++) begin
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : WORDS;
      rb0 = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 63) == 0)
          rstep(1, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        else
          rstep(0, 1, (w == 0) ? rb0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      for (int g = 0; g < int'($urandom_range(1, 2)); g++)
        rstep(0, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
